// File: rtl/wb_sram_bridge.sv
// ---------------------------------------------------------------------------
// wb_sram_bridge
//
// Wishbone-classic slave that carries 32-bit CPU word accesses onto the
// request interface of a 48-bit external static-RAM controller. Each bus
// word occupies the low DATA_W bits of one SRAM location. The upper bits are
// written as zero and are discarded on reads. Only one transaction is in
// flight at a time. The CPU stalls until ack.
//
// Ports
//   clk         in   1        single clock, all state on the rising edge
//   rst         in   1        asynchronous active-high reset
//   stb         in   1        bus strobe, held by the master until ack
//   addra       in   30       word address (byte address [31:2])
//   dina        in   DATA_W   write data
//   wea         in   1        1 = write, 0 = read
//   douta       out  DATA_W   read data, registered, holds the last read
//   ack         out  1        transfer complete, registered
//   sram_stb    out  1        request to the SRAM controller, registered
//   sram_addra  out  SRAM_AW  SRAM word address
//   sram_dina   out  SRAM_DW  SRAM write data, {zero, dina}
//   sram_we     out  1        SRAM write enable
//   sram_douta  in   SRAM_DW  SRAM read data, valid while sram_ack = 1
//   sram_ack    in   1        SRAM completion; may rise in the same cycle
//                             as sram_stb
// ---------------------------------------------------------------------------
module wb_sram_bridge #(
    parameter int SRAM_AW = 20,
    parameter int DATA_W  = 32,
    parameter int SRAM_DW = 48
) (
    input  logic               clk,
    input  logic               rst,

    // Wishbone-classic slave side
    input  logic               stb,
    input  logic [29:0]        addra,
    input  logic [DATA_W-1:0]  dina,
    input  logic               wea,
    output logic [DATA_W-1:0]  douta,
    output logic               ack,

    // SRAM controller request side
    output logic               sram_stb,
    output logic [SRAM_AW-1:0] sram_addra,
    output logic [SRAM_DW-1:0] sram_dina,
    output logic               sram_we,
    input  logic [SRAM_DW-1:0] sram_douta,
    input  logic               sram_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for a strobe
        S_REQ  = 2'd1,   // request presented to SRAM, waiting for sram_ack
        S_DONE = 2'd2    // ack raised, waiting for the master to drop stb
    } state_t;

    state_t               state_q;
    logic                 ack_q;
    logic                 sram_stb_q;
    logic                 sram_we_q;
    logic [SRAM_AW-1:0]   sram_addr_q;
    logic [SRAM_DW-1:0]   sram_data_q;
    logic [DATA_W-1:0]    douta_q;

    // The upper address bits alias the SRAM modulo 2^SRAM_AW words.
    // The upper SRAM read bits hold no bus data. Both are dropped on purpose.
    logic unused_bits;
    assign unused_bits = ^{addra[29:SRAM_AW], sram_douta[SRAM_DW-1:DATA_W]};

    // -----------------------------------------------------------------------
    // Single-process FSM. Every output comes straight from a flop, so the
    // bus and the SRAM controller never see a combinational path through
    // the bridge.
    // -----------------------------------------------------------------------
    // NOTE: every register here takes <= so all flops update together from
    // values sampled at the same edge. Blocking = would let a later line see
    // this cycle's new value and build a different circuit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Reset clears all outputs at once. Any transaction in flight is
            // dropped.
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            sram_stb_q  <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            douta_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    if (stb) begin
                        // Capture the request once. Later changes on
                        // addra/dina/wea do not affect this transaction.
                        sram_addr_q <= addra[SRAM_AW-1:0];
                        sram_data_q <= {{(SRAM_DW-DATA_W){1'b0}}, dina};
                        sram_we_q   <= wea;
                        sram_stb_q  <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Request fields stay frozen until the controller
                    // completes. The SRAM op is never cancelled.
                    if (sram_ack) begin
                        sram_stb_q <= 1'b0;
                        sram_we_q  <= 1'b0;
                        if (!sram_we_q) begin
                            douta_q <= sram_douta[DATA_W-1:0];
                        end
                        if (stb) begin
                            ack_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            // The master gave up while the SRAM was busy.
                            // Finish quietly with no ack.
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_DONE: begin
                    // Hold ack until the master drops stb. A new request is
                    // taken only from IDLE, so stb must be low for at least
                    // one cycle between transfers.
                    if (!stb) begin
                        ack_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    ack_q      <= 1'b0;
                    sram_stb_q <= 1'b0;
                    sram_we_q  <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign douta      = douta_q;
    assign ack        = ack_q;
    assign sram_stb   = sram_stb_q;
    assign sram_addra = sram_addr_q;
    assign sram_dina  = sram_data_q;
    assign sram_we    = sram_we_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_sram_bridge
//
// Directed bench for wb_sram_bridge. The bench holds a small SRAM controller
// model with a programmable number of wait states. When a transaction is
// driven, its expected SRAM request and its expected read data are pushed to
// scoreboard queues. They are popped and compared when the DUT issues the
// request and when it raises ack.
// ---------------------------------------------------------------------------
module tb_wb_sram_bridge;

    typedef struct packed {
        logic [19:0] addr;
        logic [47:0] data;
        logic        we;
    } req_t;

    logic        clk;
    logic        rst;
    logic        stb;
    logic [29:0] addra;
    logic [31:0] dina;
    logic        wea;
    logic [31:0] douta;
    logic        ack;
    logic        sram_stb;
    logic [19:0] sram_addra;
    logic [47:0] sram_dina;
    logic        sram_we;
    logic [47:0] sram_douta;
    logic        sram_ack;

    int checks = 0;
    int errors = 0;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] shadow [logic [19:0]];
    logic [47:0] mem    [logic [19:0]];
    logic [31:0] last_rd;

    int wait_cfg;
    int wcnt;

    wb_sram_bridge #(
        .SRAM_AW(20),
        .DATA_W (32),
        .SRAM_DW(48)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stb       (stb),
        .addra     (addra),
        .dina      (dina),
        .wea       (wea),
        .douta     (douta),
        .ack       (ack),
        .sram_stb  (sram_stb),
        .sram_addra(sram_addra),
        .sram_dina (sram_dina),
        .sram_we   (sram_we),
        .sram_douta(sram_douta),
        .sram_ack  (sram_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // SRAM controller model. sram_ack follows sram_stb after wait_cfg extra
    // cycles, and is combinational when wait_cfg = 0.
    // -----------------------------------------------------------------------
    assign sram_ack = sram_stb && (wcnt == wait_cfg);

    always @(posedge clk) begin
        if (sram_stb && sram_ack) wcnt <= 0;
        else if (sram_stb)        wcnt <= wcnt + 1;
        else                      wcnt <= 0;
    end

    // The handshake is observed mid-cycle. The request is checked against
    // the scoreboard, and the memory is updated. Read data is presented
    // until the next edge. When no read is pending, a junk pattern is
    // driven so that a bridge sampling at the wrong time is exposed.
    always @(negedge clk) begin
        req_t r;
        sram_douta = 48'hBAD0_BAD0_BAD0;
        if (!rst && sram_stb && sram_ack) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_sram_req observed=%h expected=none", sram_addra);
            end else begin
                r = req_q.pop_front();
                check("sram_addra", 48'(sram_addra), 48'(r.addr));
                check("sram_dina",  sram_dina,       r.data);
                check("sram_we",    48'(sram_we),    48'(r.we));
            end
            if (sram_we) begin
                mem[sram_addra] = sram_dina;
            end else begin
                sram_douta = {16'h1234, (mem.exists(sram_addra) ? mem[sram_addra][31:0] : 32'h0)};
            end
        end
    end

    // Drive a new request on a falling edge and push its expectations.
    task automatic start(input logic [29:0] a, input logic [31:0] d, input logic w, input int waits);
        req_t r;
        r.addr = a[19:0];
        r.data = {16'h0, d};
        r.we   = w;
        req_q.push_back(r);
        if (w) shadow[a[19:0]] = d;
        else   rd_q.push_back(shadow.exists(a[19:0]) ? shadow[a[19:0]] : 32'h0);
        wait_cfg = waits;
        addra    = a;
        dina     = d;
        wea      = w;
        stb      = 1'b1;
    endtask

    // Full transfer. Checks latency, request stability, read data (or that
    // douta is held on a write), ack hold, and ack release.
    task automatic xfer(input logic [29:0] a, input logic [31:0] d, input logic w,
                        input int waits, input int hold);
        int          cyc;
        logic [31:0] exp_rd;
        start(a, d, w, waits);
        @(negedge clk);
        check("sram_stb_issued", 48'(sram_stb), 48'(1'b1));
        check("ack_early",       48'(ack),      48'(1'b0));
        // Scramble the bus inputs. The latched request must not change.
        addra = ~a;
        dina  = ~d;
        wea   = ~w;
        cyc   = 1;
        while (!ack && cyc < 60) begin
            check("hold_sram_stb",  48'(sram_stb),   48'(1'b1));
            check("hold_sram_addr", 48'(sram_addra), 48'(a[19:0]));
            check("hold_sram_we",   48'(sram_we),    48'(w));
            @(negedge clk);
            cyc++;
        end
        check("ack_latency", 48'(cyc), 48'(2 + waits));
        if (!w) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rd_queue_empty observed=empty expected=entry");
            end else begin
                exp_rd  = rd_q.pop_front();
                last_rd = exp_rd;
                check("douta_read", 48'(douta), 48'(exp_rd));
            end
        end else begin
            check("douta_held", 48'(douta), 48'(last_rd));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ack_held", 48'(ack), 48'(1'b1));
        end
        stb = 1'b0;
        @(negedge clk);
        check("ack_release",  48'(ack),      48'(1'b0));
        check("sram_stb_low", 48'(sram_stb), 48'(1'b0));
        check("sram_we_low",  48'(sram_we),  48'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int saw_ack;
        rst      = 1'b1;
        stb      = 1'b0;
        addra    = '0;
        dina     = '0;
        wea      = 1'b0;
        wait_cfg = 0;
        wcnt     = 0;
        last_rd  = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack",      48'(ack),        48'(0));
        check("rst_sram_stb", 48'(sram_stb),   48'(0));
        check("rst_sram_we",  48'(sram_we),    48'(0));
        check("rst_douta",    48'(douta),      48'(0));
        check("rst_addra",    48'(sram_addra), 48'(0));
        check("rst_dina",     sram_dina,       48'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1 write, zero-wait SRAM
        xfer(30'h00010, 32'hDEADBEEF, 1'b1, 0, 0);
        @(negedge clk);
        // 2 read back, ack held while stb stays high
        xfer(30'h00010, 32'h0, 1'b0, 0, 2);
        @(negedge clk);
        // 3 wait states on write and read
        xfer(30'h00011, 32'h0BADF00D, 1'b1, 5, 0);
        @(negedge clk);
        xfer(30'h00011, 32'h0, 1'b0, 3, 1);
        @(negedge clk);

        // 4 master abort during REQ
        start(30'h00020, 32'hCAFEF00D, 1'b1, 4);
        @(negedge clk);
        check("abort_sram_stb", 48'(sram_stb), 48'(1));
        @(negedge clk);
        stb     = 1'b0;
        saw_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack) saw_ack = 1;
        end
        check("abort_no_ack",     48'(saw_ack),       48'(0));
        check("abort_sram_done",  48'(sram_stb),      48'(0));
        check("abort_req_popped", 48'(req_q.size()),  48'(0));
        xfer(30'h00020, 32'h0, 1'b0, 0, 0);
        @(negedge clk);

        // 5 address alias: upper bits ignored
        xfer(30'h3FF00004, 32'h55AA1234, 1'b1, 1, 0);
        @(negedge clk);
        xfer(30'h00004, 32'h0, 1'b0, 0, 0);
        @(negedge clk);

        // 6 reset in the middle of a read that is waiting on the SRAM
        start(30'h00011, 32'h0, 1'b0, 6);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_sram_stb", 48'(sram_stb), 48'(1));
        #2 rst = 1'b1;
        #1;
        check("midrst_ack",      48'(ack),        48'(0));
        check("midrst_sram_stb", 48'(sram_stb),   48'(0));
        check("midrst_sram_we",  48'(sram_we),    48'(0));
        check("midrst_douta",    48'(douta),      48'(0));
        check("midrst_addra",    48'(sram_addra), 48'(0));
        req_q.delete();
        rd_q.delete();
        last_rd = 32'h0;
        stb     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // A fresh transaction after reset
        xfer(30'h00010, 32'h0, 1'b0, 0, 0);
        @(negedge clk);
        check("final_queue_empty", 48'(req_q.size()), 48'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
